// File: rtl/tdm_demux4_if.sv
// Serial-in / frame-out signal bundle for the 4-slot TDM receiver.
// The ch_vld strobe exists only when TDM_CH_VLD_EN is defined.
interface tdm_demux4_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0]   din;
  logic            din_vld;
  logic            fsync;
  logic [4*DW-1:0] dout;
  logic            frame_vld;
  logic            locked;
  logic            sync_err;
`ifdef TDM_CH_VLD_EN
  logic [3:0]      ch_vld;
`endif

  modport master (
    output din, din_vld, fsync,
`ifdef TDM_CH_VLD_EN
    input  ch_vld,
`endif
    input  dout, frame_vld, locked, sync_err
  );

  modport slave (
    input  din, din_vld, fsync,
`ifdef TDM_CH_VLD_EN
    output ch_vld,
`endif
    output dout, frame_vld, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM receiver: slot-0 fsync alignment, flywheel lock, atomic frame output.
// Optional per-channel strobe ch_vld enabled by defining TDM_CH_VLD_EN.
module tdm_demux4 #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MISS_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux4_if.slave bus
);

  localparam logic [3:0] MissMax = 4'(MISS_MAX);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             slot_q, slot_d;
  logic [3:0]             miss_q, miss_d;
  logic [2:0][DW-1:0]     sh_q, sh_d;
  logic [4*DW-1:0]        dout_q, dout_d;
  logic                   frame_vld_q, frame_vld_d;
  logic                   sync_err_q, sync_err_d;
  logic                   store_en;
  logic [1:0]             store_slot;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    miss_d      = miss_q;
    sh_d        = sh_q;
    dout_d      = dout_q;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;
    store_en    = 1'b0;
    store_slot  = slot_q;

    if (bus.din_vld) begin
      unique case (state_q)
        StHunt: begin
          if (bus.fsync) begin
            store_en   = 1'b1;
            store_slot = 2'd0;
            slot_d     = 2'd1;
            miss_d     = 4'd0;
            state_d    = StLock;
          end
        end
        StLock: begin
          if (bus.fsync && slot_q != 2'd0) begin
            // Realign: drop the partial frame and restart at slot 0.
            sync_err_d = 1'b1;
            store_en   = 1'b1;
            store_slot = 2'd0;
            slot_d     = 2'd1;
            miss_d     = 4'd0;
          end else if (slot_q == 2'd0) begin
            if (bus.fsync) begin
              miss_d     = 4'd0;
              store_en   = 1'b1;
              slot_d     = 2'd1;
            end else if (miss_q + 4'd1 >= MissMax) begin
              state_d = StHunt;
              slot_d  = 2'd0;
              miss_d  = 4'd0;
            end else begin
              // Flywheel: trust the slot counter for a missing marker.
              miss_d   = miss_q + 4'd1;
              store_en = 1'b1;
              slot_d   = 2'd1;
            end
          end else begin
            store_en = 1'b1;
            slot_d   = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              dout_d      = {bus.din, sh_q};
              frame_vld_d = 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (store_en) begin
      unique case (store_slot)
        2'd0:    sh_d[0] = bus.din;
        2'd1:    sh_d[1] = bus.din;
        2'd2:    sh_d[2] = bus.din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      slot_q      <= 2'd0;
      miss_q      <= 4'd0;
      sh_q        <= '0;
      dout_q      <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      miss_q      <= miss_d;
      sh_q        <= sh_d;
      dout_q      <= dout_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.frame_vld = frame_vld_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.locked    = (state_q == StLock);

`ifdef TDM_CH_VLD_EN
  logic [3:0] ch_vld_q, ch_vld_d;

  always_comb begin
    ch_vld_d = 4'b0000;
    if (store_en) ch_vld_d[store_slot] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ch_vld_q <= 4'b0000;
    else     ch_vld_q <= ch_vld_d;
  end

  assign bus.ch_vld = ch_vld_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized self-checking bench for tdm_demux4 against a queue-based frame model.
module tb_tdm_demux4;
  localparam int unsigned DW       = 8;
  localparam int unsigned MISS_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux4_if #(.DW(DW)) bus ();

  tdm_demux4 #(.DW(DW), .MISS_MAX(MISS_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a receiver either hunts or holds a list of samples collected for the current frame.
  bit               m_locked;
  int               m_miss;
  logic [DW-1:0]    m_part[$];
  logic [4*DW-1:0]  e_dout;
  bit               e_fv, e_se;
  logic [3:0]       e_ch;

  task automatic model_reset();
    m_locked = 0;
    m_miss   = 0;
    m_part.delete();
    e_dout = '0;
    e_fv = 0; e_se = 0; e_ch = 4'b0000;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit fs);
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1; m_miss = 0;
        m_part.delete(); m_part.push_back(d);
        e_ch = 4'b0001;
      end
    end else if (fs && m_part.size() != 0) begin
      e_se = 1; m_miss = 0;
      m_part.delete(); m_part.push_back(d);
      e_ch = 4'b0001;
    end else if (m_part.size() == 0) begin
      if (fs) begin
        m_miss = 0; m_part.push_back(d); e_ch = 4'b0001;
      end else begin
        m_miss++;
        if (m_miss >= MISS_MAX) begin
          m_locked = 0; m_miss = 0;
        end else begin
          m_part.push_back(d); e_ch = 4'b0001;
        end
      end
    end else begin
      e_ch = 4'b0001 << m_part.size();
      m_part.push_back(d);
      if (m_part.size() == 4) begin
        e_dout = {m_part[3], m_part[2], m_part[1], m_part[0]};
        e_fv = 1;
        m_part.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".dout"},      64'(bus.dout),      64'(e_dout));
    check_eq({tag, ".frame_vld"}, 64'(bus.frame_vld), 64'(e_fv));
    check_eq({tag, ".locked"},    64'(bus.locked),    64'(m_locked));
    check_eq({tag, ".sync_err"},  64'(bus.sync_err),  64'(e_se));
`ifdef TDM_CH_VLD_EN
    check_eq({tag, ".ch_vld"},    64'(bus.ch_vld),    64'(e_ch));
`endif
  endtask

  // Called at a negedge; drives one cycle and checks the registered result one edge later.
  task automatic step(input string tag, input bit vld, input logic [DW-1:0] d, input bit fs);
    bus.din_vld = vld;
    bus.din     = d;
    bus.fsync   = fs;
    e_fv = 0; e_se = 0; e_ch = 4'b0000;
    if (vld) model_beat(d, fs);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, DW'($urandom), 1'($urandom));
  endtask

  task automatic frame(input string tag, input logic [4*DW-1:0] f, input bit fs0);
    step(tag, 1'b1, f[0*DW +: DW], fs0);
    step(tag, 1'b1, f[1*DW +: DW], 1'b0);
    step(tag, 1'b1, f[2*DW +: DW], 1'b0);
    step(tag, 1'b1, f[3*DW +: DW], 1'b0);
  endtask

  initial begin
    int up_slot;
    bit fs;
    bus.din_vld = 1'b0;
    bus.din     = '0;
    bus.fsync   = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all("post_reset");

    // Aligned back-to-back frame.
    frame("t1", 32'hD3C2B1A0, 1'b1);

    // Same frame with idle gaps.
    for (int i = 0; i < 4; i++) begin
      logic [4*DW-1:0] f;
      f = 32'hD3C2B1A0;
      step("t2", 1'b1, f[i*DW +: DW], i == 0);
      idle("t2_idle");
      idle("t2_idle");
    end

    // Misplaced fsync while locked.
    step("t3", 1'b1, 8'h11, 1'b1);
    step("t3", 1'b1, 8'h22, 1'b0);
    step("t3", 1'b1, 8'h33, 1'b1);
    step("t3", 1'b1, 8'h44, 1'b0);
    step("t3", 1'b1, 8'h55, 1'b0);
    step("t3", 1'b1, 8'h66, 1'b0);

    // Flywheel then loss of lock, then relock.
    frame("t4_lock", 32'h04030201, 1'b1);
    frame("t4_m1",   32'h14131211, 1'b0);
    frame("t4_m2",   32'h24232221, 1'b0);
    frame("t4_m3",   32'h34333231, 1'b0);
    frame("t4_relock", 32'h44434241, 1'b1);

    // Asynchronous reset mid-frame.
    step("t5", 1'b1, 8'hA0, 1'b1);
    step("t5", 1'b1, 8'hB1, 1'b0);
    step("t5", 1'b1, 8'hC2, 1'b0);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all("t5_async");
    @(negedge clk);
    rst = 1'b0;
    step("t5_ign", 1'b1, 8'hD3, 1'b0);
    step("t5_ign", 1'b1, 8'hE4, 1'b0);
    frame("t5_after", 32'h87654321, 1'b1);

    // Randomized traffic: mostly aligned markers with dropouts and slips.
    up_slot = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        if (up_slot == 0) fs = ($urandom_range(0, 9) != 0);
        else              fs = ($urandom_range(0, 40) == 0);
        step("rand", 1'b1, DW'($urandom), fs);
        up_slot = (up_slot + 1) % 4;
        if ($urandom_range(0, 99) == 0) up_slot = $urandom_range(0, 3);
      end else begin
        idle("rand_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
